// File: rtl/boxcar_pkg.sv
// Shared sizing and rounding helpers for the boxcar moving-average filter.
package boxcar_pkg;

    // Largest supported window exponent (window of 256 samples).
    localparam int MAX_LOG2_N = 8;

    // Width of the running sum: a full window of N samples needs LOG2_N extra bits.
    function automatic int sum_width(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

    // Bias added before the divide-by-N shift; half an LSB of the quotient when rounding.
    function automatic int round_const(input int log2_n, input bit round);
        if (!round || log2_n == 0) begin
            return 0;
        end
        return 1 << (log2_n - 1);
    endfunction

endpackage

// File: rtl/boxcar_filter_n_if.sv
// Sample stream in, averaged stream out, for the boxcar filter.
interface boxcar_filter_n_if
    import boxcar_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3
);
    localparam int SUM_W = sum_width(DATA_W, LOG2_N);

    logic              i_clear;
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic [SUM_W-1:0]  o_sum;
    logic              o_full;

    modport master (
        output i_clear, i_valid, i_data,
        input  o_valid, o_data, o_sum, o_full
    );

    modport slave (
        input  i_clear, i_valid, i_data,
        output o_valid, o_data, o_sum, o_full
    );

endinterface

// File: rtl/boxcar_delay_line.sv
// N-entry circular sample buffer; presents the sample about to be overwritten.
module boxcar_delay_line #(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clear,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_old
);
    localparam int N     = 1 << LOG2_N;
    // A window of one still gets a 1-bit pointer; it simply never leaves 0.
    localparam int PTR_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int DEPTH = 1 << PTR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;

    // Write pointer: advances per stored sample, wraps at N-1, cleared by reset or flush.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            wr_ptr <= '0;
        end else if (i_we) begin
            wr_ptr <= (wr_ptr == PTR_W'(N - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Sample storage: no reset, stale entries are masked by the fill count upstream.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Read-before-write: the oldest sample leaves in the same cycle its slot is refilled.
    assign o_old = mem[wr_ptr];

endmodule

// File: rtl/boxcar_filter_n.sv
// Boxcar moving-average filter over a window of 2^LOG2_N samples, one-cycle latency.
module boxcar_filter_n
    import boxcar_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG2_N = 3,
    parameter int SIGNED = 0,
    parameter int ROUND  = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    boxcar_filter_n_if.slave bus
);
    localparam int SUM_W = sum_width(DATA_W, LOG2_N);
    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int RND   = round_const(LOG2_N, ROUND != 0);

    logic [DATA_W-1:0]        old_p0;
    logic signed [SUM_W-1:0]  in_ext;
    logic signed [SUM_W-1:0]  old_ext;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  sum_p0;
    logic [CNT_W-1:0]         cnt_p0;
    logic [CNT_W-1:0]         cnt_next;
    logic                     full_now;
    logic                     accept;

    logic                     vld_p1;
    logic [DATA_W-1:0]        avg_p1;
    logic                     full_p1;

    // Widen a sample to sum precision, honouring the sample signedness.
    function automatic logic signed [SUM_W-1:0] extend(input logic [DATA_W-1:0] d);
        if (SIGNED != 0) begin
            return SUM_W'($signed(d));
        end
        return SUM_W'(d);
    endfunction

    // Divide the window sum by N (floor, or round-half-up), keep DATA_W bits.
    function automatic logic [DATA_W-1:0] average(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W:0] biased;
        logic signed [SUM_W:0] shifted;
        if (SIGNED != 0) begin
            biased = (SUM_W + 1)'(s);
        end else begin
            biased = (SUM_W + 1)'($unsigned(s));
        end
        biased  = biased + (SUM_W + 1)'(RND);
        shifted = biased >>> LOG2_N;
        return shifted[DATA_W-1:0];
    endfunction

    // A flush always discards the sample presented alongside it.
    assign accept = bus.i_valid && !bus.i_clear;

    boxcar_delay_line #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_delay_line (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (bus.i_clear),
        .i_we      (accept),
        .i_data    (bus.i_data),
        .o_old     (old_p0)
    );

    // Running-sum update: add the new sample, drop the departing one once the window is full.
    always_comb begin
        in_ext   = extend(bus.i_data);
        full_now = (cnt_p0 == CNT_W'(N));
        old_ext  = full_now ? extend(old_p0) : '0;
        sum_next = sum_p0 + in_ext - old_ext;
        cnt_next = full_now ? cnt_p0 : cnt_p0 + CNT_W'(1);
    end

    // Accumulator, fill count and registered outputs; reset and flush both empty the window.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || bus.i_clear) begin
            sum_p0  <= '0;
            cnt_p0  <= '0;
            vld_p1  <= 1'b0;
            avg_p1  <= '0;
            full_p1 <= 1'b0;
        end else if (bus.i_valid) begin
            sum_p0  <= sum_next;
            cnt_p0  <= cnt_next;
            vld_p1  <= 1'b1;
            avg_p1  <= average(sum_next);
            full_p1 <= (cnt_next == CNT_W'(N));
        end else begin
            vld_p1  <= 1'b0;
        end
    end

    assign bus.o_valid = vld_p1;
    assign bus.o_data  = avg_p1;
    assign bus.o_sum   = sum_p0;
    assign bus.o_full  = full_p1;

endmodule

// File: tb/tb_boxcar_filter_n.sv
// Bench for boxcar_filter_n: five configurations share one stimulus stream.
module tb_boxcar_filter_n;

    localparam int NCFG = 5;
    localparam int CFG_L [NCFG] = '{2, 2, 2, 2, 0};
    localparam int CFG_S [NCFG] = '{0, 0, 1, 1, 0};
    localparam int CFG_R [NCFG] = '{0, 1, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       vld;
    logic [7:0] din;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    longint hist[$];
    bit     exp_valid;
    longint exp_sum  [NCFG];
    longint exp_data [NCFG];
    bit     exp_full [NCFG];

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Window average straight from the definition: sum of the last N accepted samples
    // (absent ones are zero), then floor((sum + bias) / N).
    function automatic void model(input int s, input int r, input int l,
                                  output longint es, output longint ed, output bit ef);
        int     n;
        int     k;
        longint sum;
        longint num;
        longint q;
        longint v;
        n   = 1 << l;
        k   = (hist.size() < n) ? hist.size() : n;
        sum = 0;
        for (int i = 0; i < k; i++) begin
            v = hist[hist.size() - 1 - i];
            if (s != 0 && v >= 128) v = v - 256;
            sum = sum + v;
        end
        num = sum + ((r != 0 && l > 0) ? longint'(n / 2) : 64'sd0);
        q   = num / n;
        if ((num % n) != 0 && num < 0) q = q - 1;
        es = sum & ((64'sd1 << (8 + l)) - 1);
        ed = q & 255;
        ef = (hist.size() >= n);
    endfunction

    always @(posedge clk) begin
        if (!rst_n || clr) begin
            hist.delete();
            exp_valid = 1'b0;
            for (int c = 0; c < NCFG; c++) begin
                exp_sum[c]  = 0;
                exp_data[c] = 0;
                exp_full[c] = 1'b0;
            end
            chk_en = 1'b1;
        end else if (vld) begin
            hist.push_back(longint'(din));
            if (hist.size() > 300) void'(hist.pop_front());
            exp_valid = 1'b1;
            for (int c = 0; c < NCFG; c++) begin
                model(CFG_S[c], CFG_R[c], CFG_L[c], exp_sum[c], exp_data[c], exp_full[c]);
            end
        end else begin
            exp_valid = 1'b0;
        end
    end

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        boxcar_filter_n_if #(.DATA_W(8), .LOG2_N(CFG_L[g])) bus ();

        assign bus.i_clear = clr;
        assign bus.i_valid = vld;
        assign bus.i_data  = din;

        boxcar_filter_n #(
            .DATA_W (8),
            .LOG2_N (CFG_L[g]),
            .SIGNED (CFG_S[g]),
            .ROUND  (CFG_R[g])
        ) dut (
            .i_clk     (clk),
            .i_reset_n (rst_n),
            .bus       (bus)
        );

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("cfg%0d o_valid", g), longint'(bus.o_valid), longint'(exp_valid));
                check($sformatf("cfg%0d o_data", g),  longint'(bus.o_data),  exp_data[g]);
                check($sformatf("cfg%0d o_sum", g),   longint'(bus.o_sum),   exp_sum[g]);
                check($sformatf("cfg%0d o_full", g),  longint'(bus.o_full),  longint'(exp_full[g]));
            end
        end
    end

    task automatic drive(input bit rn, input bit c, input bit v, input logic [7:0] d);
        rst_n = rn;
        clr   = c;
        vld   = v;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d31 [5];
        int s31 [5];
        d31 = '{1, 3, 6, 10, 14};
        s31 = '{4, 12, 24, 40, 56};

        drive(0, 0, 0, 8'd0);
        drive(0, 0, 0, 8'd0);
        check("reset o_valid", longint'(g_dut[0].bus.o_valid), 0);
        check("reset o_data",  longint'(g_dut[0].bus.o_data),  0);
        check("reset o_sum",   longint'(g_dut[0].bus.o_sum),   0);
        check("reset o_full",  longint'(g_dut[0].bus.o_full),  0);

        // Ramp 4..20 filling and then sliding the window.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 8'(4 * (i + 1)));
            check($sformatf("ramp%0d o_data", i), longint'(g_dut[0].bus.o_data), d31[i]);
            check($sformatf("ramp%0d o_sum", i),  longint'(g_dut[0].bus.o_sum),  s31[i]);
            check($sformatf("ramp%0d o_full", i), longint'(g_dut[0].bus.o_full), (i >= 3) ? 1 : 0);
            check($sformatf("ramp%0d o_valid", i), longint'(g_dut[0].bus.o_valid), 1);
        end
        check("n1 o_data", longint'(g_dut[4].bus.o_data), 20);
        check("n1 o_sum",  longint'(g_dut[4].bus.o_sum),  20);
        drive(1, 0, 0, 8'd0);

        // Full-scale samples: no wrap in any configuration.
        drive(0, 0, 0, 8'd0);
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 8'hFF);
        check("max u o_sum",       longint'(g_dut[0].bus.o_sum),  1020);
        check("max u o_data",      longint'(g_dut[0].bus.o_data), 255);
        check("max u rnd o_sum",   longint'(g_dut[1].bus.o_sum),  1020);
        check("max u rnd o_data",  longint'(g_dut[1].bus.o_data), 255);
        check("max s o_sum",       longint'(g_dut[2].bus.o_sum),  'h3FC);
        check("max s o_data",      longint'(g_dut[2].bus.o_data), 'hFF);
        check("max s rnd o_data",  longint'(g_dut[3].bus.o_data), 'hFF);

        // Single -1 sample: floor gives -1, rounding gives 0.
        drive(0, 0, 0, 8'd0);
        drive(1, 0, 1, 8'hFF);
        check("neg1 s o_sum",      longint'(g_dut[2].bus.o_sum),  'h3FF);
        check("neg1 s o_data",     longint'(g_dut[2].bus.o_data), 'hFF);
        check("neg1 s rnd o_data", longint'(g_dut[3].bus.o_data), 'h00);
        check("neg1 n1 o_data",    longint'(g_dut[4].bus.o_data), 'hFF);

        // Sparse samples with idle gaps: outputs hold between pulses.
        drive(0, 0, 0, 8'd0);
        drive(1, 0, 1, 8'd10);
        check("gap s1 o_valid", longint'(g_dut[0].bus.o_valid), 1);
        check("gap s1 o_data",  longint'(g_dut[0].bus.o_data),  2);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 8'd55);
            check($sformatf("gap idle%0d o_valid", i), longint'(g_dut[0].bus.o_valid), 0);
            check($sformatf("gap idle%0d o_data", i),  longint'(g_dut[0].bus.o_data),  2);
        end
        drive(1, 0, 1, 8'd20);
        check("gap s2 o_data", longint'(g_dut[0].bus.o_data), 7);
        check("gap s2 o_sum",  longint'(g_dut[0].bus.o_sum),  30);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 8'd0);
            check($sformatf("gap2 idle%0d o_data", i), longint'(g_dut[0].bus.o_data), 7);
        end

        // Flush with a simultaneous sample: flush wins.
        drive(0, 0, 0, 8'd0);
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 8'd8);
        check("pre-clear o_full", longint'(g_dut[0].bus.o_full), 1);
        drive(1, 1, 1, 8'd100);
        check("clear o_valid", longint'(g_dut[0].bus.o_valid), 0);
        check("clear o_data",  longint'(g_dut[0].bus.o_data),  0);
        check("clear o_sum",   longint'(g_dut[0].bus.o_sum),   0);
        check("clear o_full",  longint'(g_dut[0].bus.o_full),  0);
        drive(1, 0, 1, 8'd8);
        check("post-clear o_data", longint'(g_dut[0].bus.o_data), 2);
        check("post-clear o_sum",  longint'(g_dut[0].bus.o_sum),  8);
        check("post-clear o_full", longint'(g_dut[0].bus.o_full), 0);

        // Reset mid-window discards history.
        drive(0, 0, 0, 8'd0);
        drive(1, 0, 1, 8'd50);
        drive(1, 0, 1, 8'd60);
        drive(1, 0, 1, 8'd70);
        drive(0, 0, 1, 8'd99);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 8'd40);
            check($sformatf("rst hist%0d o_data", i), longint'(g_dut[0].bus.o_data), 10 * (i + 1));
        end

        drive(1, 0, 0, 8'd0);
        drive(1, 0, 0, 8'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/boxcar_filter_n.md
BOXCAR_FILTER_N -- requirements
Module: boxcar_filter_n

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits (2..32).
REQ-002 Parameter LOG2_N, default 3, window length N = 2^LOG2_N samples (0..8).
REQ-003 Parameter SIGNED, default 0, 1 = two's-complement samples, 0 = unsigned.
REQ-004 Parameter ROUND, default 0, 1 = round-half-up before divide, 0 = truncate (floor).
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_reset_n  input  1  reset, synchronous, active-low.
REQ-007 i_clear  input  1  synchronous window flush.
REQ-008 i_valid  input  1  qualifies i_data; one sample accepted per cycle when high.
REQ-009 i_data  input  DATA_W  input sample.
REQ-010 o_valid  output  1  one-cycle pulse, o_data/o_sum updated.
REQ-011 o_data  output  DATA_W  window average, registered.
REQ-012 o_sum  output  DATA_W+LOG2_N  running window sum, registered, sign per SIGNED.
REQ-013 o_full  output  1  high once N samples accepted since reset/clear.

Function
REQ-014 The block SHALL hold an N-entry circular sample buffer, write pointer wr_ptr (LOG2_N bits, wraps N-1 -> 0) and fill counter cnt (saturates at N).
REQ-015 On an accepted sample the block SHALL compute sum_next = sum + i_data - old, where old = buffer[wr_ptr] if cnt == N, else 0.
REQ-016 On an accepted sample the block SHALL write buffer[wr_ptr] <= i_data, advance wr_ptr, and increment cnt unless saturated.
REQ-017 Sum arithmetic SHALL be DATA_W+LOG2_N bits, sign-extended when SIGNED=1, zero-extended otherwise; it SHALL never overflow.
REQ-018 o_data SHALL equal sum_next >> LOG2_N (arithmetic shift when SIGNED=1); with ROUND=1, (sum_next + 2^(LOG2_N-1)) >> LOG2_N, truncated to DATA_W bits.
REQ-019 Latency SHALL be exactly one cycle: o_valid, o_data, o_sum valid the cycle after i_valid is sampled high.
REQ-020 When no sample is accepted, o_valid SHALL be 0 and o_data, o_sum, o_full SHALL hold.
REQ-021 Before the window fills, missing samples SHALL count as zero (average = sum / N, not sum / cnt).
REQ-022 o_full SHALL rise in the same cycle o_valid reports the Nth accepted sample.
REQ-023 i_clear SHALL set sum, cnt, wr_ptr, o_sum, o_data, o_full to 0 and o_valid to 0 next cycle; buffer contents need not be cleared.
REQ-024 i_clear and i_valid in the same cycle: clear wins, sample discarded.
REQ-025 LOG2_N = 0: o_data SHALL equal the last accepted sample; ROUND has no effect.

Reset
REQ-026 With i_reset_n low at a rising edge: o_valid=0, o_data=0, o_sum=0, o_full=0, sum=0, cnt=0, wr_ptr=0.
REQ-027 Reset SHALL take priority over i_clear and i_valid; reset mid-window discards all history.
REQ-028 Buffer storage SHALL NOT require reset (masked by cnt per REQ-015).

Structure
REQ-029 Shared package boxcar_pkg SHALL hold the sum-width function (DATA_W+LOG2_N) and the rounding-constant function.
REQ-030 One sub-module, boxcar_delay_line (N x DATA_W circular buffer, write pointer, read-before-write old-sample output), SHALL be used; accumulator and output logic stay in the top.

Verification (DATA_W=8, LOG2_N=2 unless stated)
REQ-031 Reset, then valid samples 4,8,12,16,20 -> o_data 1,3,6,10,14; o_sum 4,12,24,40,56; o_full high from 4th output.
REQ-032 Four 255 samples, ROUND=0 and ROUND=1 -> o_sum 1020, o_data 255, no wrap.
REQ-033 SIGNED=1, one sample 0xFF -> o_sum -1, o_data 0xFF (ROUND=0) / 0x00 (ROUND=1); four 0xFF -> o_sum -4, o_data 0xFF.
REQ-034 Samples 10,20 with i_valid gaps of 3 idle cycles -> o_valid pulses only one cycle after each sample, o_data 2 then 7 held through gaps.
REQ-035 After window full, i_clear asserted together with i_valid=1, i_data=100 -> next cycle all outputs 0, o_valid 0; then sample 8 -> o_data 2, o_full 0.
REQ-036 i_reset_n low for one cycle after 3 samples, then 4 samples of 40 -> o_data 10,20,30,40, no contribution from pre-reset history.
